// File: rtl/ipml_fifo_v2_0_sync_ctrl.sv
// ipml_fifo_v2_0_sync_ctrl
// Single-clock FIFO with an inferred simple-dual-port memory of 2^N words,
// selectable standard / first-word-fall-through read mode, programmable
// almost-full / almost-empty thresholds, synchronous flush and error pulses.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   clr               synchronous flush, wins over wr_en / rd_en
//   wr_data, wr_en    write word and request; wr_full reports a full FIFO
//   almost_full(_th)  flag raised while water_level >= almost_full_th
//   rd_en, rd_data    read request (standard) or head acknowledge (FWFT)
//   rd_empty          no word available on the read side
//   almost_empty(_th) flag raised while water_level <= almost_empty_th
//   water_level       words held, 0..2^N (includes the FWFT head word)
//   overflow          one-cycle pulse after a rejected write
//   underflow         one-cycle pulse after a rejected read
module ipml_fifo_v2_0_sync_ctrl #(
    parameter int c_DEPTH_WIDTH = 9,
    parameter int c_DATA_WIDTH  = 32,
    parameter int c_FWFT        = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [c_DATA_WIDTH-1:0]  wr_data,
    input  logic                     wr_en,
    output logic                     wr_full,
    output logic                     almost_full,
    input  logic [c_DEPTH_WIDTH:0]   almost_full_th,
    input  logic                     rd_en,
    output logic [c_DATA_WIDTH-1:0]  rd_data,
    output logic                     rd_empty,
    output logic                     almost_empty,
    input  logic [c_DEPTH_WIDTH:0]   almost_empty_th,
    output logic [c_DEPTH_WIDTH:0]   water_level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int DEPTH = 1 << c_DEPTH_WIDTH;
    localparam bit FWFT  = (c_FWFT != 0);
    localparam logic [c_DEPTH_WIDTH:0] FULL_LEVEL = {1'b1, {c_DEPTH_WIDTH{1'b0}}};

    logic [c_DATA_WIDTH-1:0]  mem [DEPTH];
    logic [c_DEPTH_WIDTH-1:0] wr_addr;
    logic [c_DEPTH_WIDTH-1:0] rd_addr;
    logic [c_DEPTH_WIDTH:0]   mem_count;
    logic                     head_valid;

    logic                     wr_accept;
    logic                     rd_accept;
    logic                     mem_rd;
    logic [c_DEPTH_WIDTH:0]   count_next;
    logic                     valid_next;
    logic [c_DEPTH_WIDTH:0]   level_next;

    // Request acceptance and next-state occupancy.
    // In FWFT mode the output register acts as one extra storage slot: a
    // memory read is issued whenever that slot is free or being consumed,
    // so the memory count excludes the head word while water_level includes it.
    always_comb begin
        wr_accept  = wr_en & ~wr_full & ~clr;
        rd_accept  = rd_en & ~rd_empty & ~clr;
        mem_rd     = 1'b0;
        valid_next = 1'b0;
        if (FWFT) begin
            mem_rd     = (~head_valid | rd_accept) & (mem_count != '0) & ~clr;
            valid_next = mem_rd | (head_valid & ~rd_accept);
        end else begin
            mem_rd     = rd_accept;
        end

        count_next = mem_count;
        if (wr_accept && !mem_rd) begin
            count_next = mem_count + 1'b1;
        end else if (!wr_accept && mem_rd) begin
            count_next = mem_count - 1'b1;
        end

        level_next = count_next + {{c_DEPTH_WIDTH{1'b0}}, valid_next};
    end

    // Storage array; left without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Pointers, occupancy, output register and flags. Flags are registered
    // from the next-state level so they line up with water_level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr      <= '0;
            rd_addr      <= '0;
            mem_count    <= '0;
            head_valid   <= 1'b0;
            rd_data      <= '0;
            water_level  <= '0;
            wr_full      <= 1'b0;
            rd_empty     <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clr) begin
            wr_addr      <= '0;
            rd_addr      <= '0;
            mem_count    <= '0;
            head_valid   <= 1'b0;
            rd_data      <= '0;
            water_level  <= '0;
            wr_full      <= 1'b0;
            rd_empty     <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_addr <= wr_addr + 1'b1;
            end
            if (mem_rd) begin
                rd_addr <= rd_addr + 1'b1;
                rd_data <= mem[rd_addr];
            end
            mem_count    <= count_next;
            head_valid   <= valid_next;
            water_level  <= level_next;
            wr_full      <= (level_next == FULL_LEVEL);
            rd_empty     <= FWFT ? ~valid_next : (level_next == '0);
            almost_full  <= (level_next >= almost_full_th);
            almost_empty <= (level_next <= almost_empty_th);
            overflow     <= wr_en & wr_full;
            underflow    <= rd_en & rd_empty;
        end
    end

endmodule

// File: tb/tb_ipml_fifo_v2_0_sync_ctrl.sv
// tb_ipml_fifo_v2_0_sync_ctrl
// Directed bench for ipml_fifo_v2_0_sync_ctrl with N=4, 8-bit data.
// Instance s_dut runs standard mode, instance f_dut runs FWFT mode.
module tb_ipml_fifo_v2_0_sync_ctrl;

    logic       clk;
    logic       rst;

    logic       s_clr, s_wr_en, s_rd_en;
    logic [7:0] s_wr_data, s_rd_data;
    logic       s_wr_full, s_almost_full, s_rd_empty, s_almost_empty;
    logic       s_overflow, s_underflow;
    logic [4:0] s_af_th, s_ae_th, s_level;

    logic       f_clr, f_wr_en, f_rd_en;
    logic [7:0] f_wr_data, f_rd_data;
    logic       f_wr_full, f_almost_full, f_rd_empty, f_almost_empty;
    logic       f_overflow, f_underflow;
    logic [4:0] f_af_th, f_ae_th, f_level;

    int vectors;
    int miscompares;

    ipml_fifo_v2_0_sync_ctrl #(.c_DEPTH_WIDTH(4), .c_DATA_WIDTH(8), .c_FWFT(0)) s_dut (
        .clk(clk), .rst(rst), .clr(s_clr),
        .wr_data(s_wr_data), .wr_en(s_wr_en), .wr_full(s_wr_full),
        .almost_full(s_almost_full), .almost_full_th(s_af_th),
        .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_empty(s_rd_empty),
        .almost_empty(s_almost_empty), .almost_empty_th(s_ae_th),
        .water_level(s_level), .overflow(s_overflow), .underflow(s_underflow)
    );

    ipml_fifo_v2_0_sync_ctrl #(.c_DEPTH_WIDTH(4), .c_DATA_WIDTH(8), .c_FWFT(1)) f_dut (
        .clk(clk), .rst(rst), .clr(f_clr),
        .wr_data(f_wr_data), .wr_en(f_wr_en), .wr_full(f_wr_full),
        .almost_full(f_almost_full), .almost_full_th(f_af_th),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_empty(f_rd_empty),
        .almost_empty(f_almost_empty), .almost_empty_th(f_ae_th),
        .water_level(f_level), .overflow(f_overflow), .underflow(f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every output of the standard instance against its reset value.
    task automatic check_std_reset(input string tag);
        check_output({tag, " s_rd_data"}, 32'(s_rd_data), 32'h0);
        check_output({tag, " s_rd_empty"}, 32'(s_rd_empty), 32'h1);
        check_output({tag, " s_wr_full"}, 32'(s_wr_full), 32'h0);
        check_output({tag, " s_almost_full"}, 32'(s_almost_full), 32'h0);
        check_output({tag, " s_almost_empty"}, 32'(s_almost_empty), 32'h1);
        check_output({tag, " s_level"}, 32'(s_level), 32'h0);
        check_output({tag, " s_overflow"}, 32'(s_overflow), 32'h0);
        check_output({tag, " s_underflow"}, 32'(s_underflow), 32'h0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        s_clr = 0; s_wr_en = 0; s_rd_en = 0; s_wr_data = 0;
        f_clr = 0; f_wr_en = 0; f_rd_en = 0; f_wr_data = 0;
        s_af_th = 5'd12; s_ae_th = 5'd3;
        f_af_th = 5'd12; f_ae_th = 5'd3;

        tick();
        tick();
        check_std_reset("reset");
        check_output("reset f_rd_empty", 32'(f_rd_empty), 32'h1);
        check_output("reset f_level", 32'(f_level), 32'h0);
        rst = 1'b0;
        tick();

        // Fill standard FIFO with 0..15, watching level and threshold flags
        for (int i = 0; i < 16; i++) begin
            s_wr_en = 1; s_wr_data = 8'(i);
            tick();
            check_output($sformatf("fill level %0d", i), 32'(s_level), 32'(i + 1));
            check_output($sformatf("fill almost_full %0d", i), 32'(s_almost_full),
                         32'((i + 1) >= 12));
            check_output($sformatf("fill almost_empty %0d", i), 32'(s_almost_empty),
                         32'((i + 1) <= 3));
            check_output($sformatf("fill wr_full %0d", i), 32'(s_wr_full), 32'(i == 15));
            check_output($sformatf("fill rd_empty %0d", i), 32'(s_rd_empty), 32'h0);
        end

        // 17th write is rejected
        s_wr_data = 8'hEE;
        tick();
        s_wr_en = 0;
        check_output("17th write overflow", 32'(s_overflow), 32'h1);
        check_output("17th write level", 32'(s_level), 32'd16);
        tick();
        check_output("overflow one cycle", 32'(s_overflow), 32'h0);

        // Drain 16 words in order
        for (int i = 0; i < 16; i++) begin
            s_rd_en = 1;
            tick();
            check_output($sformatf("drain data %0d", i), 32'(s_rd_data), 32'(i));
            check_output($sformatf("drain level %0d", i), 32'(s_level), 32'(15 - i));
            check_output($sformatf("drain rd_empty %0d", i), 32'(s_rd_empty), 32'(i == 15));
            check_output($sformatf("drain almost_empty %0d", i), 32'(s_almost_empty),
                         32'((15 - i) <= 3));
        end
        tick();
        s_rd_en = 0;
        check_output("empty read underflow", 32'(s_underflow), 32'h1);
        check_output("empty read rd_data", 32'(s_rd_data), 32'd15);
        check_output("empty read level", 32'(s_level), 32'd0);
        tick();
        check_output("underflow one cycle", 32'(s_underflow), 32'h0);

        // Preload 8 words, then 40 cycles of simultaneous write+read across wrap
        for (int i = 0; i < 8; i++) begin
            s_wr_en = 1; s_wr_data = 8'(i);
            tick();
        end
        check_output("preload level", 32'(s_level), 32'd8);
        for (int i = 0; i < 40; i++) begin
            s_wr_en = 1; s_rd_en = 1; s_wr_data = 8'(i + 8);
            tick();
            check_output($sformatf("simul level %0d", i), 32'(s_level), 32'd8);
            check_output($sformatf("simul data %0d", i), 32'(s_rd_data), 32'(i));
        end
        s_rd_en = 0;

        // Top up to full (holds 40..55), then write+read at full
        for (int i = 0; i < 8; i++) begin
            s_wr_data = 8'(48 + i);
            tick();
        end
        check_output("refill wr_full", 32'(s_wr_full), 32'h1);
        s_rd_en = 1; s_wr_data = 8'hCC;
        tick();
        s_wr_en = 0; s_rd_en = 0;
        check_output("full simul overflow", 32'(s_overflow), 32'h1);
        check_output("full simul level", 32'(s_level), 32'd15);
        check_output("full simul data", 32'(s_rd_data), 32'd40);

        // Read down to level 9, then flush with a concurrent write
        s_rd_en = 1;
        for (int i = 0; i < 6; i++) tick();
        s_rd_en = 0;
        check_output("pre-flush level", 32'(s_level), 32'd9);
        check_output("pre-flush data", 32'(s_rd_data), 32'd46);
        s_clr = 1; s_wr_en = 1; s_wr_data = 8'h99;
        tick();
        s_clr = 0; s_wr_en = 0;
        check_output("flush level", 32'(s_level), 32'd0);
        check_output("flush rd_empty", 32'(s_rd_empty), 32'h1);
        check_output("flush overflow", 32'(s_overflow), 32'h0);
        check_output("flush rd_data", 32'(s_rd_data), 32'h0);
        check_output("flush almost_empty", 32'(s_almost_empty), 32'h1);

        // After flush, a fresh word goes straight through
        s_wr_en = 1; s_wr_data = 8'h77;
        tick();
        s_wr_en = 0; s_rd_en = 1;
        tick();
        s_rd_en = 0;
        check_output("post-flush data", 32'(s_rd_data), 32'h77);
        check_output("post-flush level", 32'(s_level), 32'd0);

        // FWFT: single write of 0xA5 at edge k
        f_wr_en = 1; f_wr_data = 8'hA5;
        tick();
        f_wr_en = 0;
        check_output("fwft edge k rd_empty", 32'(f_rd_empty), 32'h1);
        tick();
        check_output("fwft edge k+1 rd_empty", 32'(f_rd_empty), 32'h0);
        check_output("fwft edge k+1 rd_data", 32'(f_rd_data), 32'hA5);
        check_output("fwft edge k+1 level", 32'(f_level), 32'd1);
        f_rd_en = 1;
        tick();
        f_rd_en = 0;
        check_output("fwft ack rd_empty", 32'(f_rd_empty), 32'h1);
        check_output("fwft ack level", 32'(f_level), 32'd0);
        check_output("fwft ack underflow", 32'(f_underflow), 32'h0);

        // FWFT: burst of three, then acknowledges back to back
        f_wr_en = 1;
        for (int i = 1; i <= 3; i++) begin
            f_wr_data = 8'hB0 + 8'(i);
            tick();
        end
        f_wr_en = 0;
        check_output("fwft burst level", 32'(f_level), 32'd3);
        check_output("fwft burst head", 32'(f_rd_data), 32'hB1);
        f_rd_en = 1;
        tick();
        check_output("fwft ack1 data", 32'(f_rd_data), 32'hB2);
        check_output("fwft ack1 level", 32'(f_level), 32'd2);
        tick();
        check_output("fwft ack2 data", 32'(f_rd_data), 32'hB3);
        check_output("fwft ack2 level", 32'(f_level), 32'd1);
        tick();
        check_output("fwft ack3 rd_empty", 32'(f_rd_empty), 32'h1);
        check_output("fwft ack3 level", 32'(f_level), 32'd0);
        tick();
        f_rd_en = 0;
        check_output("fwft empty ack underflow", 32'(f_underflow), 32'h1);

        // FWFT capacity is exactly 16 words
        f_wr_en = 1;
        for (int i = 0; i < 16; i++) begin
            f_wr_data = 8'h10 + 8'(i);
            tick();
        end
        check_output("fwft full wr_full", 32'(f_wr_full), 32'h1);
        check_output("fwft full level", 32'(f_level), 32'd16);
        check_output("fwft full head", 32'(f_rd_data), 32'h10);
        check_output("fwft full almost_full", 32'(f_almost_full), 32'h1);
        f_wr_data = 8'hEE;
        tick();
        check_output("fwft 17th overflow", 32'(f_overflow), 32'h1);
        check_output("fwft 17th level", 32'(f_level), 32'd16);
        f_rd_en = 1;
        tick();
        f_wr_en = 0; f_rd_en = 0;
        check_output("fwft full simul overflow", 32'(f_overflow), 32'h1);
        check_output("fwft full simul level", 32'(f_level), 32'd15);
        check_output("fwft full simul head", 32'(f_rd_data), 32'h11);

        // Asynchronous reset in the middle of a write burst
        s_wr_en = 1;
        for (int i = 0; i < 3; i++) begin
            s_wr_data = 8'h60 + 8'(i);
            tick();
        end
        check_output("burst level", 32'(s_level), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_std_reset("async rst");
        check_output("async rst f_level", 32'(f_level), 32'h0);
        check_output("async rst f_rd_empty", 32'(f_rd_empty), 32'h1);
        check_output("async rst f_rd_data", 32'(f_rd_data), 32'h0);
        s_wr_en = 0;
        tick();
        rst = 1'b0;
        tick();
        check_output("post rst level", 32'(s_level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
